mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Round-robin arbiter and sequencer that shares one 8x8 multiplier among `N_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and starts the multiplier. It then waits for the multiplier's done pulse and returns the 16-bit product to the granted requester. A watchdog aborts the job with an error if done never arrives. It sits between the processor's execute-stage clients and the shared multiplier instance.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 64: maximum cycles spent in WAIT before the job is aborted (must be > 20).
- `Clk` input 1: clock; all logic on rising edge.
- `Rst` input 1: synchronous, active-high reset.
- `req_valid` input N_REQ: per-requester request.
- `req_x` input 8*N_REQ: operand X, requester i at bits [8i+7:8i].
- `req_y` input 8*N_REQ: operand Y, same packing.
- `req_ready` output N_REQ: one-hot accept pulse; a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high.
- `resp_valid` output N_REQ: one-hot, one-cycle result pulse to the granted requester.
- `resp_data` output 16: product, qualified by `resp_valid`.
- `resp_err` output 1: high with `resp_valid` when the job timed out.
- `busy` output 1: high in every state except IDLE.
- `mul_x` output 8: drives multiplier X.
- `mul_y` output 8: drives multiplier Y.
- `mul_start` output 1: one-cycle start pulse, wired to the multiplier's load/start input.
- `mul_o` input 16: multiplier product.
- `mul_done` input 1: multiplier completion pulse; `mul_o` is valid while it is high.

## Operation
- States: IDLE, START, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is high, grant index g: the first requester with `req_valid` set, scanning upward from `last_grant+1` modulo N_REQ.
  - Assert `req_ready[g]` combinationally in this cycle.
  - Latch `req_x[g]`/`req_y[g]` into the operand registers and g into `grant`; go to START.
  - With no request, stay in IDLE; all pulse outputs are 0.
- **START**: `mul_start`=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- **WAIT**
  - On `mul_done`=1, capture `mul_o` into `resp_data`, clear `resp_err`, go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT-1 without done, set `resp_data`=0 and `resp_err`=1, then go to RESP.
  - If `mul_done` arrives in the same cycle the counter reaches TIMEOUT-1, the done wins and no error is flagged.
- **RESP**: `resp_valid[grant]`=1 for one cycle; update `last_grant`<=grant; go to IDLE.
- `mul_x`/`mul_y` are driven from the operand registers and stay stable from START until the next accept.
- `mul_done` seen outside WAIT is ignored.
- Requester-side rules:
  - A requester may drop `req_valid` before it is accepted, and no grant results.
  - Operands must be stable while `req_valid` is high and `req_ready` is low.
  - `req_valid` held after acceptance is treated as a new request in a later IDLE cycle.
- After a timeout, the arbiter returns to IDLE normally. Recovering a hung multiplier is handled at system level.
- **Reset (Rst=1)**, at any state including mid-job:
  - Next state is IDLE.
  - `req_ready`, `resp_valid`, `resp_err`, `mul_start`, `busy` all 0.
  - `resp_data`, `mul_x`, `mul_y` reset to 0.
  - `last_grant` resets to N_REQ-1, so requester 0 has top priority after reset.

## Timing
- Let the accept cycle be cycle 0.
- `mul_start` is high in cycle 1.
- With the multiplier raising `mul_done` in cycle 1+L, `resp_valid` is high in cycle 2+L. L is 16 for the current multiplier, so `resp_valid` lands in cycle 18.
- The next accept is possible in cycle 3+L. Throughput is one job per L+3 cycles.
- A timeout response arrives at `resp_valid` in cycle 1+TIMEOUT.
- `req_ready` is a combinational function of the state, `req_valid` and `last_grant`. All other outputs are registered.

## Test plan
Benches use a behavioural multiplier model with programmable latency L, default 16, computing X*Y.
- **Reset then single request**: req_valid=0001, x=13, y=11 → req_ready=0001 in cycle 0, mul_start in cycle 1, resp_valid=0001 with resp_data=143, resp_err=0 in cycle 18.
- **Round-robin fairness**: all four requesters valid continuously with distinct operands (e.g. 255*255) → grants in order 0,1,2,3,0. Each result (65025 for 255*255) returns to the matching requester.
- **Skip idle requesters**: last_grant=1, req_valid=1001 → grant 3 first, then 0.
- **Timeout**: model never raises done, TIMEOUT=64 → resp_valid in cycle 65 with resp_err=1 and resp_data=0. The next request then completes normally.
- **Reset mid-job**: assert Rst in WAIT → the next cycle is IDLE with busy=0 and all outputs 0, with no resp_valid for the aborted job. The next request goes to requester 0 when all are valid.
- **Spurious done and request withdrawal**: mul_done pulsed during IDLE → ignored. req_valid dropped before grant → no req_ready or resp_valid for that requester.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one 8x8 multiplier among N_REQ requesters,
// sequencing accept -> start -> wait-for-done (with watchdog) -> response.
module mul_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_x,
   input  logic [8*N_REQ-1:0]   req_y,
   output logic [N_REQ-1:0]     req_ready,
   output logic [N_REQ-1:0]     resp_valid,
   output logic [15:0]          resp_data,
   output logic                 resp_err,
   output logic                 busy,
   output logic [7:0]           mul_x,
   output logic [7:0]           mul_y,
   output logic                 mul_start,
   input  logic [15:0]          mul_o,
   input  logic                 mul_done
);

   localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   state_t          state, state_nx;
   logic [GW-1:0]   last_grant, grant, sel, cand;
   logic            found;
   logic [7:0]      sel_x, sel_y;
   logic [CW-1:0]   wd_cnt;
   logic            wd_expire;

   // First valid requester scanning upward from last_grant+1, wrapping at N_REQ.
   always_comb begin
      sel   = last_grant;
      cand  = last_grant;
      found = 1'b0;
      for (int unsigned off = 1; off <= N_REQ; off++) begin
         cand = GW'((32'(last_grant) + off) % N_REQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_comb begin
      sel_x = '0;
      sel_y = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (sel == GW'(i)) begin
            sel_x = req_x[8*i +: 8];
            sel_y = req_y[8*i +: 8];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!Rst && state == IDLE && found)
         req_ready[sel] = 1'b1;
   end

   // Counter is compared one short of TIMEOUT-1 so the abort lands in RESP at cycle 1+TIMEOUT.
   assign wd_expire = (wd_cnt == CW'(TIMEOUT - 2));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (found) state_nx = START;
         START:   state_nx = WAIT;
         WAIT:    if (mul_done || wd_expire) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= IDLE;
         last_grant <= GW'(N_REQ - 1);
         grant      <= '0;
         mul_x      <= '0;
         mul_y      <= '0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
         resp_valid <= '0;
         mul_start  <= 1'b0;
         busy       <= 1'b0;
         wd_cnt     <= '0;
      end else begin
         state      <= state_nx;
         busy       <= (state_nx != IDLE);
         mul_start  <= (state_nx == START);
         resp_valid <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  grant <= sel;
                  mul_x <= sel_x;
                  mul_y <= sel_y;
               end
            end
            START: wd_cnt <= '0;
            WAIT: begin
               // done takes priority over a watchdog expiry in the same cycle
               if (mul_done) begin
                  resp_data         <= mul_o;
                  resp_err          <= 1'b0;
                  resp_valid[grant] <= 1'b1;
               end else if (wd_expire) begin
                  resp_data         <= '0;
                  resp_err          <= 1'b1;
                  resp_valid[grant] <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            RESP: last_grant <= grant;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with a behavioural fixed-latency multiplier.
module tb_mul_arbiter;
   localparam int unsigned N   = 4;
   localparam int unsigned TO  = 64;
   localparam int unsigned LAT = 16;

   logic            Clk = 1'b0;
   logic            Rst;
   logic [N-1:0]    req_valid, req_ready, resp_valid;
   logic [8*N-1:0]  req_x, req_y;
   logic [15:0]     resp_data, mul_o;
   logic            resp_err, busy, mul_start, mul_done;
   logic [7:0]      mul_x, mul_y;

   always #5 Clk = ~Clk;

   mul_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_err(resp_err), .busy(busy), .mul_x(mul_x), .mul_y(mul_y),
      .mul_start(mul_start), .mul_o(mul_o), .mul_done(mul_done)
   );

   // Multiplier model: done pulses LAT cycles after the start cycle unless hung.
   logic        hang, spur, md_q;
   logic [7:0]  mcnt;
   logic [15:0] mprod;
   always @(posedge Clk) begin
      if (Rst) begin
         mcnt  <= '0;
         md_q  <= 1'b0;
         mprod <= '0;
      end else begin
         md_q <= (mcnt == 8'd1);
         if (mcnt != 0) mcnt <= mcnt - 8'd1;
         if (mul_start && !hang) begin
            mcnt  <= 8'(LAT - 1);
            mprod <= mul_x * mul_y;
         end
      end
   end
   assign mul_done = md_q | spur;
   assign mul_o    = mprod;

   typedef struct {int unsigned idx; logic [7:0] x; logic [7:0] y;} gnt_t;
   typedef struct {int unsigned idx; logic [15:0] data; logic err; int unsigned lat;} rsp_t;
   gnt_t gq[$];
   rsp_t rq[$];
   gnt_t g_cur;
   rsp_t r_cur;

   int          checks = 0, failures = 0;
   int unsigned cyc = 0, acc_cyc = 0, n_acc = 0;
   logic [7:0]  ex_x = '0, ex_y = '0;
   logic [N-1:0] acc_q = '0;
   logic        drop_en;

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic logic [31:0] oh(int unsigned i);
      return 32'(1) << i;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expected grants/responses as the DUT presents them.
   always @(negedge Clk) begin
      acc_q = req_valid & req_ready;
      if (!Rst) begin
         if (req_ready != 0) begin
            if (gq.size() == 0) chk("unexpected_grant", 32'(req_ready), 0);
            else begin
               g_cur = gq.pop_front();
               chk("grant", 32'(req_ready), oh(g_cur.idx));
               chk("grant_has_valid", 32'(acc_q), 32'(req_ready));
               acc_cyc = cyc;
               ex_x    = g_cur.x;
               ex_y    = g_cur.y;
               n_acc++;
            end
         end
         if (mul_start) begin
            chk("start_cycle", cyc - acc_cyc, 1);
            chk("mul_x", 32'(mul_x), 32'(ex_x));
            chk("mul_y", 32'(mul_y), 32'(ex_y));
         end
         if (resp_valid != 0) begin
            if (rq.size() == 0) chk("unexpected_resp", 32'(resp_valid), 0);
            else begin
               r_cur = rq.pop_front();
               chk("resp_valid", 32'(resp_valid), oh(r_cur.idx));
               chk("resp_data", 32'(resp_data), 32'(r_cur.data));
               chk("resp_err", 32'(resp_err), 32'(r_cur.err));
               chk("resp_latency", cyc - acc_cyc, r_cur.lat);
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
      if (drop_en) req_valid = req_valid & ~acc_q;
   endtask

   task automatic set_op(int unsigned i, logic [7:0] x, logic [7:0] y);
      req_x[8*i +: 8] = x;
      req_y[8*i +: 8] = y;
   endtask

   task automatic wait_done(int unsigned budget);
      int unsigned k = 0;
      while ((gq.size() != 0 || rq.size() != 0 || busy || req_valid != 0) && k < budget) begin
         tick();
         k++;
      end
      chk("drain_in_budget", 32'(k < budget), 1);
   endtask

   initial begin
      int unsigned n0, k;
      Rst = 1'b1; req_valid = '1; req_x = '0; req_y = '0;
      hang = 1'b0; spur = 1'b0; drop_en = 1'b1;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mul_start", 32'(mul_start), 0);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_resp_err", 32'(resp_err), 0);
      chk("rst_resp_data", 32'(resp_data), 0);
      chk("rst_mul_x", 32'(mul_x), 0);
      chk("rst_mul_y", 32'(mul_y), 0);
      req_valid = '0;
      @(posedge Clk); #1 Rst = 1'b0;

      // spurious done while idle
      spur = 1'b1; tick(); spur = 1'b0;
      @(negedge Clk);
      chk("spur_busy", 32'(busy), 0);
      chk("spur_resp_valid", 32'(resp_valid), 0);
      tick();

      // single request 13*11
      set_op(0, 8'd13, 8'd11);
      gq.push_back('{0, 8'd13, 8'd11}); rq.push_back('{0, 16'd143, 1'b0, 18});
      req_valid = 4'b0001;
      wait_done(60);

      // requester 2 raises valid while busy, then withdraws before any grant
      set_op(1, 8'd3, 8'd5);
      gq.push_back('{1, 8'd3, 8'd5}); rq.push_back('{1, 16'd15, 1'b0, 18});
      req_valid = 4'b0010;
      tick();
      set_op(2, 8'd50, 8'd50);
      req_valid[2] = 1'b1;
      repeat (5) tick();
      req_valid[2] = 1'b0;
      wait_done(60);

      // last_grant=1 with 1001 pending: 3 first, then 0
      set_op(3, 8'd20, 8'd30); set_op(0, 8'd9, 8'd9);
      gq.push_back('{3, 8'd20, 8'd30}); gq.push_back('{0, 8'd9, 8'd9});
      rq.push_back('{3, 16'd600, 1'b0, 18}); rq.push_back('{0, 16'd81, 1'b0, 18});
      req_valid = 4'b1001;
      wait_done(100);

      // timeout, then a normal job
      hang = 1'b1;
      set_op(2, 8'd7, 8'd9);
      gq.push_back('{2, 8'd7, 8'd9}); rq.push_back('{2, 16'd0, 1'b1, TO + 1});
      req_valid = 4'b0100;
      wait_done(120);
      hang = 1'b0;
      set_op(2, 8'd4, 8'd6);
      gq.push_back('{2, 8'd4, 8'd6}); rq.push_back('{2, 16'd24, 1'b0, 18});
      req_valid = 4'b0100;
      wait_done(60);

      // reset while the job waits on the multiplier
      set_op(3, 8'd1, 8'd1);
      gq.push_back('{3, 8'd1, 8'd1});
      req_valid = 4'b1000;
      repeat (6) tick();
      Rst = 1'b1;
      tick();
      Rst = 1'b0; req_valid = '0;
      @(negedge Clk);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_resp_valid", 32'(resp_valid), 0);
      chk("mid_rst_mul_start", 32'(mul_start), 0);
      chk("mid_rst_mul_x", 32'(mul_x), 0);
      chk("mid_rst_mul_y", 32'(mul_y), 0);
      chk("mid_rst_resp_data", 32'(resp_data), 0);
      chk("mid_rst_resp_err", 32'(resp_err), 0);
      repeat (25) tick();

      // all requesters held valid: grants 0,1,2,3,0
      drop_en = 1'b0;
      set_op(0, 8'd255, 8'd255); set_op(1, 8'd100, 8'd200);
      set_op(2, 8'd17, 8'd15);   set_op(3, 8'd12, 8'd12);
      gq.push_back('{0, 8'd255, 8'd255}); rq.push_back('{0, 16'd65025, 1'b0, 18});
      gq.push_back('{1, 8'd100, 8'd200}); rq.push_back('{1, 16'd20000, 1'b0, 18});
      gq.push_back('{2, 8'd17, 8'd15});   rq.push_back('{2, 16'd255, 1'b0, 18});
      gq.push_back('{3, 8'd12, 8'd12});   rq.push_back('{3, 16'd144, 1'b0, 18});
      gq.push_back('{0, 8'd255, 8'd255}); rq.push_back('{0, 16'd65025, 1'b0, 18});
      n0 = n_acc; k = 0;
      req_valid = '1;
      while (n_acc < n0 + 5 && k < 200) begin
         tick();
         k++;
      end
      req_valid = '0;
      drop_en = 1'b1;
      chk("rr_accepts_in_budget", 32'(k < 200), 1);
      wait_done(100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
